// File: rtl/game_pkg.sv
// game_pkg: shared definitions for the racing-game sequencer.
//   - state_t : FSM state encoding, also exported on game_state
//   - GP_*    : default values for the game_ctrl parameters
package game_pkg;

  localparam int ST_W = 3;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_COUNTDOWN = 3'd1,
    ST_RUNNING   = 3'd2,
    ST_PAUSED    = 3'd3,
    ST_CRASH     = 3'd4,
    ST_OVER      = 3'd5
  } state_t;

  localparam int GP_STEP_DIV        = 834;
  localparam int GP_COUNTDOWN_STEPS = 90;
  localparam int GP_CRASH_STEPS     = 60;
  localparam int GP_LEVEL_STEPS     = 1024;
  localparam int GP_VEL_INIT        = 2;
  localparam int GP_VEL_MAX         = 8;
  localparam int GP_LIVES_INIT      = 3;

endpackage

// File: rtl/btn_sync.sv
// btn_sync: 2-FF synchronizer for a raw asynchronous button followed by a
// registered rising-edge detector. A held button yields one pulse; the
// button must be released before another pulse can occur.
// Ports:
//   iVGA_CLK  in  clock
//   iRST      in  asynchronous active-high reset
//   i_btn     in  raw button level
//   o_ev      out one-cycle pulse, 3 edges after the first sampling edge
module btn_sync (
  input  logic iVGA_CLK,
  input  logic iRST,
  input  logic i_btn,
  output logic o_ev
);

  logic r_meta, r_sync, r_prev, r_ev;

  always_ff @(posedge iVGA_CLK or posedge iRST) begin
    if (iRST) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
      r_ev   <= 1'b0;
    end else begin
      r_meta <= i_btn;
      r_sync <= r_meta;
      r_prev <= r_sync;
      r_ev   <= r_sync & ~r_prev;
    end
  end

  assign o_ev = r_ev;

endmodule

// File: rtl/game_ctrl.sv
// game_ctrl: game-flow sequencer. Owns the IDLE/COUNTDOWN/RUNNING/PAUSED/
// CRASH/OVER state machine, the step timebase, score, level and lives, and
// drives the obstacle datapath (reset_game, move_tick, obs_vel).
// Build option: GAME_LIVES_EN enables the lives register and respawn from
// CRASH; otherwise lives is tied to 1 and CRASH always ends the game.
// Ports:
//   iVGA_CLK    in   clock (only clock)
//   iRST        in   asynchronous active-high reset
//   start_btn   in   raw start button
//   pause_btn   in   raw pause button
//   collision   in   collision level, synchronous
//   reset_game  out  1-cycle pulse on every COUNTDOWN entry from start/respawn
//   move_tick   out  1-cycle pulse per RUNNING step
//   obs_vel     out  obstacle velocity, pixels per step
//   score       out  steps survived, saturating
//   lives       out  remaining lives
//   game_state  out  current state encoding
module game_ctrl
  import game_pkg::*;
#(
  parameter int STEP_DIV        = GP_STEP_DIV,
  parameter int COUNTDOWN_STEPS = GP_COUNTDOWN_STEPS,
  parameter int CRASH_STEPS     = GP_CRASH_STEPS,
  parameter int LEVEL_STEPS     = GP_LEVEL_STEPS,
  parameter int VEL_INIT        = GP_VEL_INIT,
  parameter int VEL_MAX         = GP_VEL_MAX,
  parameter int LIVES_INIT      = GP_LIVES_INIT
) (
  input  logic            iVGA_CLK,
  input  logic            iRST,
  input  logic            start_btn,
  input  logic            pause_btn,
  input  logic            collision,
  output logic            reset_game,
  output logic            move_tick,
  output logic [3:0]      obs_vel,
  output logic [15:0]     score,
  output logic [1:0]      lives,
  output logic [ST_W-1:0] game_state
);

  localparam int SW   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int DMAX = (COUNTDOWN_STEPS > CRASH_STEPS) ? COUNTDOWN_STEPS : CRASH_STEPS;
  localparam int DW   = $clog2(DMAX + 1);
  localparam int LW   = $clog2(LEVEL_STEPS + 1);

  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_DIV - 1);
  localparam logic [DW-1:0] CD_LAST   = DW'(COUNTDOWN_STEPS - 1);
  localparam logic [DW-1:0] CR_LAST   = DW'(CRASH_STEPS - 1);
  localparam logic [LW-1:0] LVL_LAST  = LW'(LEVEL_STEPS - 1);
  localparam logic [3:0]    VI        = 4'(VEL_INIT);
  localparam logic [3:0]    VM        = 4'(VEL_MAX);
`ifdef GAME_LIVES_EN
  localparam logic [1:0]    LI        = 2'(LIVES_INIT);
`else
  localparam int unused_lives_init = LIVES_INIT;
`endif

  logic w_start_ev, w_pause_ev, w_step;

  btn_sync u_start (.iVGA_CLK(iVGA_CLK), .iRST(iRST), .i_btn(start_btn), .o_ev(w_start_ev));
  btn_sync u_pause (.iVGA_CLK(iVGA_CLK), .iRST(iRST), .i_btn(pause_btn), .o_ev(w_pause_ev));

  state_t          r_state, w_state_nx;
  logic [SW-1:0]   r_step_cnt, w_step_nx;
  logic [DW-1:0]   r_dwell, w_dwell_nx;
  logic [LW-1:0]   r_lvl, w_lvl_nx;
  logic [15:0]     r_score, w_score_nx;
  logic [3:0]      r_vel, w_vel_nx;
  logic            r_reset_game, w_rg_nx;
  logic            r_move_tick, w_mt_nx;
`ifdef GAME_LIVES_EN
  logic [1:0]      r_lives, w_lives_nx, w_lives_dec;
  assign w_lives_dec = r_lives - 2'd1;
`endif

  assign w_step = (r_step_cnt == STEP_LAST);

  always_comb begin
    w_state_nx = r_state;
    w_step_nx  = w_step ? '0 : r_step_cnt + 1'b1;
    w_dwell_nx = r_dwell;
    w_lvl_nx   = r_lvl;
    w_score_nx = r_score;
    w_vel_nx   = r_vel;
    w_rg_nx    = 1'b0;
    w_mt_nx    = 1'b0;
`ifdef GAME_LIVES_EN
    w_lives_nx = r_lives;
`endif
    case (r_state)
      ST_IDLE, ST_OVER: begin
        if (w_start_ev) begin
          w_state_nx = ST_COUNTDOWN;
          w_rg_nx    = 1'b1;
          w_score_nx = '0;
          w_vel_nx   = VI;
          w_lvl_nx   = '0;
          w_dwell_nx = '0;
          // Restart the step phase so dwell periods are whole step multiples.
          w_step_nx  = '0;
`ifdef GAME_LIVES_EN
          w_lives_nx = LI;
`endif
        end
      end
      ST_COUNTDOWN: begin
        if (w_step) begin
          if (r_dwell == CD_LAST) begin
            w_state_nx = ST_RUNNING;
            w_dwell_nx = '0;
          end else begin
            w_dwell_nx = r_dwell + 1'b1;
          end
        end
      end
      ST_RUNNING: begin
        // Collision beats both the step and a coincident pause event.
        if (collision) begin
          w_state_nx = ST_CRASH;
          w_dwell_nx = '0;
          w_step_nx  = '0;
        end else begin
          if (w_step) begin
            w_mt_nx    = 1'b1;
            w_score_nx = (r_score == 16'hFFFF) ? r_score : r_score + 16'd1;
            if (r_lvl == LVL_LAST) begin
              w_lvl_nx = '0;
              w_vel_nx = (r_vel >= VM) ? r_vel : r_vel + 4'd1;
            end else begin
              w_lvl_nx = r_lvl + 1'b1;
            end
          end
          if (w_pause_ev) w_state_nx = ST_PAUSED;
        end
      end
      ST_PAUSED: begin
        if (w_pause_ev) w_state_nx = ST_RUNNING;
      end
      ST_CRASH: begin
        if (w_step) begin
          if (r_dwell == CR_LAST) begin
            w_dwell_nx = '0;
`ifdef GAME_LIVES_EN
            w_lives_nx = w_lives_dec;
            if (w_lives_dec == 2'd0) begin
              w_state_nx = ST_OVER;
            end else begin
              w_state_nx = ST_COUNTDOWN;
              w_rg_nx    = 1'b1;
              w_step_nx  = '0;
            end
`else
            w_state_nx = ST_OVER;
`endif
          end else begin
            w_dwell_nx = r_dwell + 1'b1;
          end
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge iVGA_CLK or posedge iRST) begin
    if (iRST) begin
      r_state      <= ST_IDLE;
      r_step_cnt   <= '0;
      r_dwell      <= '0;
      r_lvl        <= '0;
      r_score      <= '0;
      r_vel        <= VI;
      r_reset_game <= 1'b0;
      r_move_tick  <= 1'b0;
`ifdef GAME_LIVES_EN
      r_lives      <= LI;
`endif
    end else begin
      r_state      <= w_state_nx;
      r_step_cnt   <= w_step_nx;
      r_dwell      <= w_dwell_nx;
      r_lvl        <= w_lvl_nx;
      r_score      <= w_score_nx;
      r_vel        <= w_vel_nx;
      r_reset_game <= w_rg_nx;
      r_move_tick  <= w_mt_nx;
`ifdef GAME_LIVES_EN
      r_lives      <= w_lives_nx;
`endif
    end
  end

  assign reset_game = r_reset_game;
  assign move_tick  = r_move_tick;
  assign obs_vel    = r_vel;
  assign score      = r_score;
  assign game_state = r_state;
`ifdef GAME_LIVES_EN
  assign lives      = r_lives;
`else
  assign lives      = 2'd1;
`endif

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: directed table and sequences from the game rules,
// plus randomized buttons/collisions checked every cycle against a
// cycle-count based behavioural model of the game flow.
module tb_game_ctrl;

  localparam int SD = 4, CD = 3, CR = 2, LS = 5, VI = 2, VM = 4;
`ifdef GAME_LIVES_EN
  localparam int LI_EXP = 3;
`else
  localparam int LI_EXP = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_btn = 1'b0, pause_btn = 1'b0, collision = 1'b0;
  logic reset_game, move_tick;
  logic [3:0]  obs_vel;
  logic [15:0] score;
  logic [1:0]  lives;
  logic [2:0]  game_state;

  always #5 clk = ~clk;

  game_ctrl #(
    .STEP_DIV(SD), .COUNTDOWN_STEPS(CD), .CRASH_STEPS(CR), .LEVEL_STEPS(LS),
    .VEL_INIT(VI), .VEL_MAX(VM), .LIVES_INIT(3)
  ) dut (
    .iVGA_CLK(clk), .iRST(rst), .start_btn(start_btn), .pause_btn(pause_btn),
    .collision(collision), .reset_game(reset_game), .move_tick(move_tick),
    .obs_vel(obs_vel), .score(score), .lives(lives), .game_state(game_state)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Dwells are tracked in elapsed cycles since entry (COUNTDOWN lasts CD*SD
  // cycles, CRASH CR*SD); buttons become events three edges after the raw
  // rising edge is first sampled.
  typedef struct packed {
    int st, phase, dwell, lvl, score, vel, lives;
    bit rg, mt;
    bit [3:0] hs, hp;   // raw samples of previous edges, [0] = most recent
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r = '0;
    r.vel   = VI;
    r.lives = LI_EXP;
    return r;
  endfunction

  function automatic model_t step_model(model_t c, bit sb, bit pb, bit co);
    model_t n;
    bit step, sev, pev;
    n    = c;
    step = (c.phase == SD - 1);
    sev  = c.hs[2] && !c.hs[3];
    pev  = c.hp[2] && !c.hp[3];
    n.hs = {c.hs[2:0], sb};
    n.hp = {c.hp[2:0], pb};
    n.rg = 0;
    n.mt = 0;
    n.phase = step ? 0 : c.phase + 1;
    case (c.st)
      0, 5: if (sev) begin
        n.st = 1; n.rg = 1; n.score = 0; n.vel = VI; n.lives = LI_EXP;
        n.lvl = 0; n.dwell = 0; n.phase = 0;
      end
      1: begin
        n.dwell = c.dwell + 1;
        if (n.dwell == CD * SD) begin n.st = 2; n.dwell = 0; end
      end
      2: if (co) begin
        n.st = 4; n.dwell = 0; n.phase = 0;
      end else begin
        if (step) begin
          n.mt    = 1;
          n.score = (c.score >= 65535) ? 65535 : c.score + 1;
          n.lvl   = c.lvl + 1;
          if (n.lvl == LS) begin
            n.lvl = 0;
            n.vel = (c.vel + 1 > VM) ? VM : c.vel + 1;
          end
        end
        if (pev) n.st = 3;
      end
      3: if (pev) n.st = 2;
      4: begin
        n.dwell = c.dwell + 1;
        if (n.dwell == CR * SD) begin
          n.dwell = 0;
`ifdef GAME_LIVES_EN
          n.lives = c.lives - 1;
          if (n.lives == 0) n.st = 5;
          else begin n.st = 1; n.rg = 1; n.phase = 0; end
`else
          n.st = 5;
`endif
        end
      end
      default: n.st = 0;
    endcase
    return n;
  endfunction

  always @(posedge clk) m <= rst ? model_reset() : step_model(m, start_btn, pause_btn, collision);

  always @(negedge clk) begin
    #1;
    if (!rst) begin
      chk("m_state", int'(game_state), m.st);
      chk("m_reset_game", int'(reset_game), int'(m.rg));
      chk("m_move_tick", int'(move_tick), int'(m.mt));
      chk("m_obs_vel", int'(obs_vel), m.vel);
      chk("m_score", int'(score), m.score);
      chk("m_lives", int'(lives), m.lives);
    end
  end

  // ---------------- directed + random stimulus ----------------
  typedef struct {
    bit sb, pb, co;
    int st, rg, sc;
  } vec_t;

  vec_t tbl[16];

  task automatic press(input bit is_start);
    if (is_start) start_btn = 1'b1; else pause_btn = 1'b1;
    repeat (2) @(negedge clk);
    if (is_start) start_btn = 1'b0; else pause_btn = 1'b0;
  endtask

  task automatic wait_state(input int tgt, input int max, input string nm);
    bit ok = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (int'(game_state) == tgt) begin ok = 1; break; end
    end
    chk(nm, int'(ok), 1);
  endtask

  initial begin
    int ticks, sc;
    // inputs per row are applied before the edge, expectations after it
    tbl[0]  = '{1,0,0, 0,0,0};  tbl[1]  = '{1,0,0, 0,0,0};
    tbl[2]  = '{1,0,0, 0,0,0};  tbl[3]  = '{0,0,0, 1,1,0};
    tbl[4]  = '{0,0,0, 1,0,0};  tbl[5]  = '{0,1,0, 1,0,0};
    tbl[6]  = '{0,1,0, 1,0,0};  tbl[7]  = '{0,0,0, 1,0,0};
    tbl[8]  = '{0,0,1, 1,0,0};  tbl[9]  = '{0,0,0, 1,0,0};
    tbl[10] = '{1,0,0, 1,0,0};  tbl[11] = '{1,0,0, 1,0,0};
    tbl[12] = '{0,0,0, 1,0,0};  tbl[13] = '{0,0,0, 1,0,0};
    tbl[14] = '{0,0,0, 1,0,0};  tbl[15] = '{0,0,0, 2,0,0};

    // reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_state", int'(game_state), 0);
    chk("rst_reset_game", int'(reset_game), 0);
    chk("rst_move_tick", int'(move_tick), 0);
    chk("rst_obs_vel", int'(obs_vel), VI);
    chk("rst_score", int'(score), 0);
    chk("rst_lives", int'(lives), LI_EXP);
    @(negedge clk);
    rst = 1'b0;

    // start press, ignored buttons/collision during COUNTDOWN
    for (int i = 0; i < 16; i++) begin
      start_btn = tbl[i].sb; pause_btn = tbl[i].pb; collision = tbl[i].co;
      @(negedge clk);
      chk($sformatf("tbl%0d_state", i), int'(game_state), tbl[i].st);
      chk($sformatf("tbl%0d_rg", i), int'(reset_game), tbl[i].rg);
      chk($sformatf("tbl%0d_score", i), int'(score), tbl[i].sc);
    end
    start_btn = 0; pause_btn = 0; collision = 0;

    // 40 running cycles: 10 ticks, two level-ups to the ceiling
    ticks = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (move_tick) ticks++;
    end
    chk("run40_ticks", ticks, 10);
    chk("run40_score", int'(score), 10);
    chk("run40_vel", int'(obs_vel), 4);
    repeat (100 * SD) @(negedge clk);
    chk("run140_score", int'(score), 110);
    chk("run140_vel_sat", int'(obs_vel), VM);
    chk("run140_state", int'(game_state), 2);

    // pause ignores collision and freezes score
    press(0);
    wait_state(3, 10, "pause_enter");
    sc = int'(score);
    collision = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("paused_hold", int'(game_state), 3);
    end
    collision = 1'b0;
    chk("paused_score", int'(score), sc);
    press(0);
    wait_state(2, 10, "pause_exit");
    chk("unpause_score", int'(score), sc);
    repeat (6) @(negedge clk);

    // collision coincident with pause event: crash wins
    pause_btn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    pause_btn = 1'b0;
    @(negedge clk);
    collision = 1'b1;
    sc = int'(score);
    @(negedge clk);
    collision = 1'b0;
    chk("coll_pause_state", int'(game_state), 4);
    chk("coll_no_tick_score", int'(score), sc);
    repeat (7) @(negedge clk);
    chk("crash_dwell", int'(game_state), 4);
    @(negedge clk);
`ifdef GAME_LIVES_EN
    chk("respawn_state", int'(game_state), 1);
    chk("respawn_rg", int'(reset_game), 1);
    chk("respawn_lives", int'(lives), 2);
    chk("respawn_score", int'(score), sc);
    for (int k = 0; k < 2; k++) begin
      wait_state(2, 40, "respawn_run");
      collision = 1'b1;
      @(negedge clk);
      collision = 1'b0;
      chk("crash_again", int'(game_state), 4);
      for (int i = 0; i < 40; i++) begin
        if (int'(game_state) != 4) break;
        @(negedge clk);
      end
    end
    chk("over_state", int'(game_state), 5);
    chk("over_lives", int'(lives), 0);
`else
    chk("over_state", int'(game_state), 5);
    chk("over_lives", int'(lives), 1);
`endif

    // restart from OVER
    press(1);
    begin
      bit ok = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (reset_game) begin ok = 1; break; end
      end
      chk("restart_rg_seen", int'(ok), 1);
    end
    chk("restart_state", int'(game_state), 1);
    chk("restart_lives", int'(lives), LI_EXP);
    chk("restart_score", int'(score), 0);
    chk("restart_vel", int'(obs_vel), VI);
    @(negedge clk);
    chk("restart_rg_1cyc", int'(reset_game), 0);

    // asynchronous reset mid-RUNNING
    wait_state(2, 40, "rst_run");
    repeat (10) @(negedge clk);
    chk("pre_rst_score", int'(score > 0), 1);
    rst = 1'b1;
    #1;
    chk("midrst_state", int'(game_state), 0);
    chk("midrst_move_tick", int'(move_tick), 0);
    chk("midrst_score", int'(score), 0);
    chk("midrst_vel", int'(obs_vel), VI);
    chk("midrst_rg", int'(reset_game), 0);
    @(negedge clk);
    rst = 1'b0;

    // random traffic, checked every cycle by the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) start_btn = ~start_btn;
      if ($urandom_range(0, 9) == 0) pause_btn = ~pause_btn;
      collision = ($urandom_range(0, 24) == 0);
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 599) == 0) rst = 1'b1;
    end
    rst = 1'b0; start_btn = 0; pause_btn = 0; collision = 0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
    $fatal(1, "watchdog");
  end

endmodule
